time_set_editor: RTL and testbench

- Consumes the single-cycle button pulses produced by the debounce stage (one debounce instance per button).
- Lets the user edit an hours/minutes/seconds value in packed BCD: enter edit mode, select a field, increment or decrement it with wrap-around, then commit.
- On commit, issues a req/ack write handshake toward the RTC interface block.
- Sits between the debounce bank and the RTC write controller; the display path reads its outputs.

---
 rtl/time_set_pkg.sv | 46 ++++
 rtl/bcd_field_step.sv | 34 +++
 rtl/time_set_editor.sv | 140 ++++++++++++++
 tb/tb_time_set_editor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and limits for the time-set editor: FSM states, field codes,
// BCD field maxima and the field-selection rotation helpers.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EDIT  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLD_SS = 2'd0,
    FLD_MM = 2'd1,
    FLD_HH = 2'd2
  } field_e;

  // One bit per debounced button, highest priority first.
  typedef struct packed {
    logic edit;
    logic up;
    logic down;
    logic left;
    logic right;
  } btn_s;

  localparam logic [7:0] MAX_SS = 8'h59;
  localparam logic [7:0] MAX_MM = 8'h59;
  localparam logic [7:0] MAX_HH = 8'h23;

  function automatic field_e field_higher(field_e f);
    case (f)
      FLD_SS:  return FLD_MM;
      FLD_MM:  return FLD_HH;
      default: return FLD_SS;
    endcase
  endfunction

  function automatic field_e field_lower(field_e f);
    case (f)
      FLD_SS:  return FLD_HH;
      FLD_HH:  return FLD_MM;
      default: return FLD_SS;
    endcase
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// Combinational +/-1 step of one packed-BCD time field with wrap-around.
// Out-of-range inputs snap to 00 on increment and to the field maximum on decrement.
module bcd_field_step (
  input  logic [7:0] value,
  input  logic [7:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] next
);

  logic [3:0] tens;
  logic [3:0] units;
  logic       illegal;

  assign tens    = value[7:4];
  assign units   = value[3:0];
  // Binary compare matches decimal order once both digits are legal.
  assign illegal = (tens > 4'd9) || (units > 4'd9) || (value > max);

  always_comb begin
    // NOTE: default first so every path assigns next and no latch is inferred.
    next = value;
    if (inc) begin
      if (illegal || (value == max)) next = 8'h00;
      else if (units == 4'd9)        next = {tens + 4'd1, 4'd0};
      else                           next = {tens, units + 4'd1};
    end else if (dec) begin
      if (illegal || (value == 8'h00)) next = max;
      else if (units == 4'd0)          next = {tens - 4'd1, 4'd9};
      else                             next = {tens, units - 4'd1};
    end
  end

endmodule

// File: rtl/time_set_editor.sv
// Button-driven hh:mm:ss editor: tracks the RTC while idle, edits one BCD
// field at a time, and hands the result to the RTC writer over req/ack.
module time_set_editor
  import time_set_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int TO_W           = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic [7:0] edit_hh,
  output logic [7:0] edit_mm,
  output logic [7:0] edit_ss,
  output logic [1:0] field_sel,
  output logic       edit_active,
  output logic       wr_req,
  input  logic       wr_ack
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  field_e          field_q;
  btn_s            btn_now, btn_q, ev_raw, ev;
  logic [7:0]      hh_q, mm_q, ss_q;
  logic [7:0]      sel_val, sel_max, sel_d;
  logic            active_q, wr_req_q;
  logic [TO_W-1:0] to_cnt_q;

  assign btn_now = {btn_edit, btn_up, btn_down, btn_left, btn_right};
  assign ev_raw  = btn_now & ~btn_q;

  // Keep only the highest-priority event of the cycle.
  always_comb begin
    ev = '0;
    if      (ev_raw.edit)  ev.edit  = 1'b1;
    else if (ev_raw.up)    ev.up    = 1'b1;
    else if (ev_raw.down)  ev.down  = 1'b1;
    else if (ev_raw.left)  ev.left  = 1'b1;
    else if (ev_raw.right) ev.right = 1'b1;
  end

  always_comb begin
    sel_val = ss_q;
    sel_max = MAX_SS;
    unique case (field_q)
      FLD_MM:  begin sel_val = mm_q; sel_max = MAX_MM; end
      FLD_HH:  begin sel_val = hh_q; sel_max = MAX_HH; end
      default: ;
    endcase
  end

  bcd_field_step u_step (
    .value (sel_val),
    .max   (sel_max),
    .inc   (ev.up),
    .dec   (ev.down),
    .next  (sel_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the button history is reset too, so a button held through reset
      // yields one event once reset is released.
      state_q  <= IDLE;
      field_q  <= FLD_SS;
      btn_q    <= '0;
      hh_q     <= 8'h00;
      mm_q     <= 8'h00;
      ss_q     <= 8'h00;
      active_q <= 1'b0;
      wr_req_q <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      btn_q <= btn_now;
      unique case (state_q)
        IDLE: begin
          hh_q <= cur_hh;
          mm_q <= cur_mm;
          ss_q <= cur_ss;
          if (ev.edit) begin
            field_q  <= FLD_SS;
            to_cnt_q <= '0;
            active_q <= 1'b1;
            state_q  <= EDIT;
          end
        end
        EDIT: begin
          if (ev.edit) begin
            wr_req_q <= 1'b1;
            to_cnt_q <= '0;
            state_q  <= WRITE;
          end else if (ev.up || ev.down) begin
            to_cnt_q <= '0;
            unique case (field_q)
              FLD_MM:  mm_q <= sel_d;
              FLD_HH:  hh_q <= sel_d;
              default: ss_q <= sel_d;
            endcase
          end else if (ev.left) begin
            to_cnt_q <= '0;
            field_q  <= field_higher(field_q);
          end else if (ev.right) begin
            to_cnt_q <= '0;
            field_q  <= field_lower(field_q);
          end else if (to_cnt_q == TO_LAST) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (wr_ack) begin
            wr_req_q <= 1'b0;
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign edit_hh     = hh_q;
  assign edit_mm     = mm_q;
  assign edit_ss     = ss_q;
  assign field_sel   = field_q;
  assign edit_active = active_q;
  assign wr_req      = wr_req_q;

endmodule

// File: tb/tb_time_set_editor.sv
// Directed plus randomized bench for time_set_editor against a decimal-arithmetic
// reference model of the editor's behaviour.
module tb_time_set_editor;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;  // 0 edit, 1 up, 2 down, 3 left, 4 right (priority order)
  logic [7:0] cur_hh, cur_mm, cur_ss;
  logic       wr_ack;
  logic [7:0] edit_hh, edit_mm, edit_ss;
  logic [1:0] field_sel;
  logic       edit_active, wr_req;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode 0 idle, 1 edit, 2 write; m_val index 0 ss, 1 mm, 2 hh.
  int         m_mode = 0;
  int         m_field = 0;
  int         m_cnt = 0;
  bit         m_req = 1'b0;
  bit   [4:0] m_prev = '0;
  bit         skip_vals = 1'b0;
  logic [7:0] m_val [3] = '{8'h00, 8'h00, 8'h00};
  int         maxv  [3] = '{59, 59, 23};

  time_set_editor #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_edit    (btn[0]),
    .btn_up      (btn[1]),
    .btn_down    (btn[2]),
    .btn_left    (btn[3]),
    .btn_right   (btn[4]),
    .cur_hh      (cur_hh),
    .cur_mm      (cur_mm),
    .cur_ss      (cur_ss),
    .edit_hh     (edit_hh),
    .edit_mm     (edit_mm),
    .edit_ss     (edit_ss),
    .field_sel   (field_sel),
    .edit_active (edit_active),
    .wr_req      (wr_req),
    .wr_ack      (wr_ack)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [7:0] model_step(logic [7:0] v, int mx, int dir);
    int t, u, n;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    n = t * 10 + u;
    if (t > 9 || u > 9 || n > mx) return (dir > 0) ? 8'h00 : to_bcd(mx);
    return to_bcd((n + dir + mx + 1) % (mx + 1));
  endfunction

  function automatic logic [7:0] rand_field(int mx);
    if ($urandom_range(0, 15) == 0) return 8'($urandom);
    return to_bcd(int'($urandom_range(0, mx)));
  endfunction

  task automatic set_cur(int h, int m, int s);
    cur_hh = to_bcd(h);
    cur_mm = to_bcd(m);
    cur_ss = to_bcd(s);
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_edge();
    logic [4:0] ev;
    int first;
    skip_vals = 1'b0;
    if (reset) begin
      m_mode = 0; m_field = 0; m_cnt = 0; m_req = 1'b0; m_prev = '0;
      m_val = '{8'h00, 8'h00, 8'h00};
      return;
    end
    ev     = btn & ~m_prev;
    m_prev = btn;
    first  = -1;
    for (int i = 0; i < 5; i++) if (ev[i] && first < 0) first = i;
    case (m_mode)
      0: begin
        m_val = '{cur_ss, cur_mm, cur_hh};
        if (first == 0) begin m_field = 0; m_cnt = 0; m_mode = 1; end
      end
      1: begin
        if (first >= 0) begin
          m_cnt = 0;
          case (first)
            0: begin m_mode = 2; m_req = 1'b1; end
            1: m_val[m_field] = model_step(m_val[m_field], maxv[m_field], 1);
            2: m_val[m_field] = model_step(m_val[m_field], maxv[m_field], -1);
            3: m_field = (m_field + 1) % 3;
            default: m_field = (m_field + 2) % 3;
          endcase
        end else if (m_cnt == TO - 1) begin
          m_mode = 0;
          skip_vals = 1'b1;  // tracking of cur_* may resume on this or the next edge
        end else begin
          m_cnt++;
        end
      end
      default: if (wr_ack) begin m_req = 1'b0; m_mode = 0; end
    endcase
  endfunction

  task automatic compare_all();
    if (!skip_vals) begin
      check("model ss", edit_ss, m_val[0]);
      check("model mm", edit_mm, m_val[1]);
      check("model hh", edit_hh, m_val[2]);
    end
    check("model field_sel", 8'(field_sel), 8'(m_field));
    check("model edit_active", 8'(edit_active), 8'(m_mode != 0));
    check("model wr_req", 8'(wr_req), 8'(m_req));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse(int idx);
    btn[idx] = 1'b1;
    tick();
    btn[idx] = 1'b0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    btn    = '0;
    wr_ack = 1'b0;
    set_cur(12, 34, 56);
    tick();
    tick();
    check("reset ss", edit_ss, 8'h00);
    check("reset hh", edit_hh, 8'h00);
    check("reset field_sel", 8'(field_sel), 8'h0);
    check("reset edit_active", 8'(edit_active), 8'h0);
    check("reset wr_req", 8'(wr_req), 8'h0);

    reset = 1'b0;
    tick();
    check("track hh", edit_hh, 8'h12);
    check("track mm", edit_mm, 8'h34);
    check("track ss", edit_ss, 8'h56);

    btn[0] = 1'b1;
    tick();
    check("enter edit_active", 8'(edit_active), 8'h1);
    btn[0] = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) pulse(1);
    check("ss at 59", edit_ss, 8'h59);
    pulse(1);
    check("ss wrap 59->00", edit_ss, 8'h00);
    check("mm unchanged on ss wrap", edit_mm, 8'h34);
    pulse(3);
    pulse(3);
    check("field hh after left x2", 8'(field_sel), 8'h2);
    for (int i = 0; i < 12; i++) pulse(1);
    check("hh wrap 23->00", edit_hh, 8'h00);
    pulse(2);
    check("hh wrap 00->23", edit_hh, 8'h23);

    pulse(3);
    for (int i = 0; i < 10; i++) pulse(1);
    check("ss at 10", edit_ss, 8'h10);
    btn[1] = 1'b1;
    btn[3] = 1'b1;
    tick();
    check("priority up over left ss", edit_ss, 8'h11);
    check("priority up over left field", 8'(field_sel), 8'h0);
    btn[3] = 1'b0;
    for (int i = 1; i < 20; i++) begin
      btn[3] = (i == 8);
      btn[4] = (i == 15);
      tick();
    end
    btn[1] = 1'b0;
    btn[3] = 1'b0;
    btn[4] = 1'b0;
    tick();
    check("held up one increment", edit_ss, 8'h11);
    check("field after left/right", 8'(field_sel), 8'h0);

    btn[0] = 1'b1;
    tick();
    check("commit wr_req", 8'(wr_req), 8'h1);
    btn[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn[1] = i[0];
      set_cur(1, 2, i);
      tick();
      check("write wr_req held", 8'(wr_req), 8'h1);
      check("write hh frozen", edit_hh, 8'h23);
      check("write ss frozen", edit_ss, 8'h11);
    end
    btn[1] = 1'b0;
    wr_ack = 1'b1;
    tick();
    check("ack drops wr_req", 8'(wr_req), 8'h0);
    check("ack returns idle", 8'(edit_active), 8'h0);
    wr_ack = 1'b0;
    tick();

    pulse(0);
    btn[0] = 1'b1;
    wr_ack = 1'b1;
    tick();
    check("early ack wr_req high", 8'(wr_req), 8'h1);
    btn[0] = 1'b0;
    tick();
    check("early ack one-cycle wr_req", 8'(wr_req), 8'h0);
    wr_ack = 1'b0;
    tick();

    pulse(0);
    for (int i = 0; i < 14; i++) tick();
    check("timeout not yet", 8'(edit_active), 8'h1);
    tick();
    check("timeout to idle", 8'(edit_active), 8'h0);
    check("timeout no wr_req", 8'(wr_req), 8'h0);
    tick();

    pulse(0);
    for (int i = 0; i < 8; i++) tick();
    pulse(4);
    for (int i = 0; i < 14; i++) tick();
    check("timeout restarted", 8'(edit_active), 8'h1);
    tick();
    check("restarted timeout expires", 8'(edit_active), 8'h0);
    tick();

    pulse(0);
    pulse(0);
    check("pre-reset wr_req", 8'(wr_req), 8'h1);
    reset = 1'b1;
    tick();
    check("mid-write reset wr_req", 8'(wr_req), 8'h0);
    check("mid-write reset hh", edit_hh, 8'h00);
    check("mid-write reset mm", edit_mm, 8'h00);
    check("mid-write reset ss", edit_ss, 8'h00);
    check("mid-write reset field", 8'(field_sel), 8'h0);
    reset = 1'b0;
    tick();

    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) btn[i] = ($urandom_range(0, 3) == 0);
      wr_ack = ($urandom_range(0, 2) == 0);
      reset  = ($urandom_range(0, 299) == 0);
      cur_hh = rand_field(23);
      cur_mm = rand_field(59);
      cur_ss = rand_field(59);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
